// File: rtl/clint_irq_gen_if.sv
// Single-outstanding req/ack register bus between the load/store path and the CLINT.
// The master holds req until it sees the one-cycle ack.
interface clint_irq_gen_if;
  logic        bus_req;
  logic        bus_wr;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/clint_irq_gen.sv
// Machine-level interrupt sources: mtime/mtimecmp timer, msip register and external
// interrupt synchronizer, with registered msip/mtip/meip levels for mip.
module clint_irq_gen #(
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  clint_irq_gen_if.slave    bus,
  input  logic              ext_irq_in,
  output logic              msip,
  output logic              mtip,
  output logic              meip,
  output logic [63:0]       mtime
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   msip_q, msip_d;
  logic                   mtip_q, mtip_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic        accept;
  logic        wr_en;
  logic        tick;
  logic [2:0]  word;
  logic [31:0] rd_val;
  logic        addr_lsb_unused;

  assign word            = bus.bus_addr[4:2];
  assign addr_lsb_unused = ^bus.bus_addr[1:0];

  // Bus FSM: a request is taken only from IDLE, so a held req acks every other cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.bus_req) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en = accept & bus.bus_wr;
  assign tick  = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    rd_val = '0;
    case (word)
      3'd0:    rd_val = {31'd0, msip_q};
      3'd2:    rd_val = mtimecmp_q[31:0];
      3'd3:    rd_val = mtimecmp_q[63:32];
      3'd4:    rd_val = mtime_q[31:0];
      3'd5:    rd_val = mtime_q[63:32];
      default: rd_val = '0;
    endcase
  end

  // Read data is captured on the accept edge, i.e. before that edge's write or tick.
  always_comb begin
    rdata_d = '0;
    if (accept && !bus.bus_wr) rdata_d = rd_val;
  end

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_en && word == 3'd0) msip_d                  = bus.bus_wdata[0];
    if (wr_en && word == 3'd2) mtimecmp_d[31:0]        = bus.bus_wdata;
    if (wr_en && word == 3'd3) mtimecmp_d[63:32]       = bus.bus_wdata;
  end

  // A write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    if (wr_en && word == 3'd4)      mtime_d[31:0]  = bus.bus_wdata;
    else if (wr_en && word == 3'd5) mtime_d[63:32] = bus.bus_wdata;
    else if (tick)                  mtime_d        = mtime_q + 64'd1;
  end

  always_comb begin
    mtip_d = (mtime_q >= mtimecmp_q);
    sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq_in};
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      rdata_q    <= '0;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      sync_q     <= sync_d;
    end
  end

  assign bus.bus_ack   = (state_q == S_ACK);
  assign bus.bus_rdata = rdata_q;
  assign msip          = msip_q;
  assign mtip          = mtip_q;
  assign meip          = sync_q[SYNC_STAGES-1];
  assign mtime         = mtime_q;

endmodule

// File: doc/clint_irq_gen.md
Name: clint_irq_gen

Overview:
- Machine-level interrupt source block: the producer side of the pending bits that the privilege/interrupt logic consumes through mip.
- Holds the 64-bit mtime counter, the mtimecmp compare register, the msip software-interrupt register and the external-interrupt synchronizer.
- Drives registered msip/mtip/meip levels into the MCSR mip fields.
- Memory-mapped via a simple single-outstanding req/ack bus from the load/store path.

Parameters:
TICK_DIV, 1, clk_in cycles per mtime increment (≥1)
SYNC_STAGES, 2, flops in ext_irq_in synchronizer (≥2)

Ports:
clk_in  input  1  clock
reset_in  input  1  asynchronous active-high reset
bus_req  input  1  access request, level, held until bus_ack
bus_wr  input  1  1=write, 0=read; sampled with bus_req
bus_addr  input  5  byte offset, word aligned ([1:0] ignored)
bus_wdata  input  32  write data
bus_ack  output  1  one-cycle completion pulse
bus_rdata  output  32  read data, valid only while bus_ack=1, else 0
ext_irq_in  input  1  asynchronous external interrupt level
msip  output  1  machine software interrupt pending
mtip  output  1  machine timer interrupt pending
meip  output  1  machine external interrupt pending
mtime  output  64  current timer value (feeds time/timeh CSRs)

Behaviour:
- Reset (async, active-high):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - msip=0, mtip=0, meip=0, synchronizer flops=0, prescaler=0.
  - bus_ack=0, bus_rdata=0, bus FSM=IDLE.
- Register map (word offsets):
  - 0x00 msip: bit0 R/W, bits[31:1] read 0.
  - 0x08 mtimecmp[31:0]; 0x0C mtimecmp[63:32].
  - 0x10 mtime[31:0]; 0x14 mtime[63:32].
  - Any other offset: read 0, write ignored, still acked.
- Bus FSM, states IDLE and ACK:
  - IDLE & bus_req → ACK. Registers latch addr/wr/wdata on this edge.
  - In ACK: bus_ack=1 for exactly one cycle, bus_rdata driven; next state IDLE.
  - bus_req still high in the cycle after ACK is a new request (back-to-back gives ack every other cycle).
  - Writes commit on the edge that enters ACK.
  - Read data is the register value on that same edge, before that edge's increment or write (pre-update value).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick=1 when count==TICK_DIV-1.
  - TICK_DIV=1: tick every cycle.
- mtime:
  - Increments by 1 on tick; 64-bit wrap FFFF_FFFF_FFFF_FFFF → 0, no flag.
  - A bus write to either half in the same cycle as a tick: write wins for the written half, and no increment occurs that cycle, including no carry into the other half.
- mtip:
  - Registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit, evaluated on current register values.
  - So mtip rises one cycle after mtime reaches mtimecmp, and falls one cycle after mtimecmp is written above mtime.
- msip: the register bit itself; updates on the write-commit edge.
- meip:
  - Output of a SYNC_STAGES flop chain on ext_irq_in; level-sensitive, no latching.
  - Latency is SYNC_STAGES edges.
- Reset asserted mid-transaction: FSM returns to IDLE, no ack is issued, and the pending write is discarded.

Test Plan:
- Reset, then idle 5 cycles → msip=mtip=meip=0, mtime=5 (TICK_DIV=1), bus_ack never high.
- Write 0x08=10, 0x0C=0, hold → mtip=0 while mtime<10, rises the cycle after mtime==10. Then write 0x08=0xFFFF_FFFF, 0x0C=0xFFFF_FFFF → mtip falls 1 cycle after the write commits.
- TICK_DIV=4: mtime increments every 4th cycle. Write 0x10=0x55 on a tick cycle → mtime=0x55 with no +1 that cycle, next increment 4 cycles later.
- Write 0x14=0xFFFF_FFFF and 0x10=0xFFFF_FFFE → after 2 ticks mtime=0 and mtip stays 1 until mtime<mtimecmp is registered.
- Write 0x00=0xFFFF_FFFF → msip=1, read 0x00 returns 0x1. Read 0x1C → rdata 0, ack pulses once. Ack is exactly 1 cycle, 1 cycle after bus_req.
- Raise ext_irq_in → meip=1 after exactly 2 edges. Pulse reset_in during an ACK cycle of a 0x00 write → msip=0, no ack, FSM idle.
